// File: rtl/timer_bank_ctrl.sv
// Command sequencer for the multi-channel timer bank: pulses start/capture/rst_capture,
// programs alarms, reads back channel values and arbitrates alarm-hit events round-robin.
module timer_bank_ctrl #(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_INTERFACES  = 10,
  parameter int PULSE_CLKS     = 2,
  parameter int SETTLE_CLKS    = 2,
  localparam int IDX_W         = $clog2(NB_INTERFACES)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [2:0]                              cmd_op,
  input  logic [IDX_W-1:0]                        cmd_idx,
  input  logic [TIMER_BITWIDTH-1:0]               cmd_data,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [TIMER_BITWIDTH-1:0]               rsp_data,
  output logic                                    rsp_err,
  output logic [NB_INTERFACES-1:0]                start,
  output logic [NB_INTERFACES-1:0]                capture,
  output logic [NB_INTERFACES-1:0]                rst_capture,
  output logic [NB_INTERFACES-1:0]                alarm_en,
  output logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] alarm,
  input  logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] captured,
  input  logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] counter,
  input  logic [NB_INTERFACES-1:0]                alarm_hit,
  output logic                                    evt_valid,
  input  logic                                    evt_ready,
  output logic [IDX_W-1:0]                        evt_idx
);

  localparam logic [2:0] OP_START       = 3'd1;
  localparam logic [2:0] OP_CAPTURE     = 3'd2;
  localparam logic [2:0] OP_RST_CAPTURE = 3'd3;
  localparam logic [2:0] OP_ARM         = 3'd4;
  localparam logic [2:0] OP_DISARM      = 3'd5;
  localparam logic [2:0] OP_RD_CAPTURED = 3'd6;
  localparam logic [2:0] OP_RD_COUNTER  = 3'd7;

  typedef enum logic [2:0] {IDLE, PULSE, SETTLE, SAMPLE, RESP} state_t;

  state_t                    state;
  logic [2:0]                op_q;
  logic [IDX_W-1:0]          idx_q;
  logic [15:0]               cnt;
  logic [NB_INTERFACES-1:0]  pending;
  logic [NB_INTERFACES-1:0]  pending_nx;
  logic [NB_INTERFACES-1:0]  disarm_clr;
  logic [NB_INTERFACES-1:0]  evt_clr;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          ptr_nx;
  logic                      evt_hs;
  logic                      idx_ok;

  function automatic logic [NB_INTERFACES-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = '0;
    for (int k = 0; k < NB_INTERFACES; k++)
      if (k == int'(i)) onehot[k] = 1'b1;
  endfunction

  function automatic logic [TIMER_BITWIDTH-1:0] slice(
    input logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] v, input logic [IDX_W-1:0] i);
    slice = '0;
    for (int k = 0; k < NB_INTERFACES; k++)
      if (k == int'(i)) slice = v[k*TIMER_BITWIDTH +: TIMER_BITWIDTH];
  endfunction

  // Wrap-around search for the first pending channel at or after base.
  function automatic logic [IDX_W-1:0] first_from(
    input logic [NB_INTERFACES-1:0] p, input logic [IDX_W-1:0] base);
    logic found;
    int   j;
    first_from = '0;
    found      = 1'b0;
    for (int k = 0; k < NB_INTERFACES; k++) begin
      j = int'(base) + k;
      if (j >= NB_INTERFACES) j = j - NB_INTERFACES;
      if (!found && p[j]) begin
        first_from = IDX_W'(j);
        found      = 1'b1;
      end
    end
  endfunction

  assign idx_ok = int'(cmd_idx) < NB_INTERFACES;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      op_q        <= '0;
      idx_q       <= '0;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      start       <= '0;
      capture     <= '0;
      rst_capture <= '0;
      alarm_en    <= '0;
      alarm       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            idx_q     <= cmd_idx;
            if (!idx_ok) begin
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              case (cmd_op)
                OP_START, OP_CAPTURE, OP_RST_CAPTURE: begin
                  if (cmd_op == OP_START)       start       <= onehot(cmd_idx);
                  if (cmd_op == OP_CAPTURE)     capture     <= onehot(cmd_idx);
                  if (cmd_op == OP_RST_CAPTURE) rst_capture <= onehot(cmd_idx);
                  cnt   <= 16'(PULSE_CLKS - 1);
                  state <= PULSE;
                end
                OP_ARM: begin
                  for (int k = 0; k < NB_INTERFACES; k++)
                    if (k == int'(cmd_idx)) alarm[k*TIMER_BITWIDTH +: TIMER_BITWIDTH] <= cmd_data;
                  alarm_en  <= alarm_en | onehot(cmd_idx);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
                end
                OP_DISARM: begin
                  alarm_en  <= alarm_en & ~onehot(cmd_idx);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
                end
                OP_RD_CAPTURED, OP_RD_COUNTER: state <= SAMPLE;
                default: begin
                  rsp_valid <= 1'b1;
                  state     <= RESP;
                end
              endcase
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            start       <= '0;
            capture     <= '0;
            rst_capture <= '0;
            if (op_q == OP_CAPTURE) begin
              if (SETTLE_CLKS == 0) begin
                state <= SAMPLE;
              end else begin
                cnt   <= 16'(SETTLE_CLKS - 1);
                state <= SETTLE;
              end
            end else begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 16'd1;
        end
        SAMPLE: begin
          rsp_data  <= (op_q == OP_RD_COUNTER) ? slice(counter, idx_q) : slice(captured, idx_q);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A DISARM overrides a same-cycle hit; a new hit overrides a same-cycle grant clear.
  always_comb begin
    disarm_clr = '0;
    if (state == IDLE && cmd_ready && cmd_valid && idx_ok && cmd_op == OP_DISARM)
      disarm_clr = onehot(cmd_idx);
    evt_hs     = evt_valid && evt_ready;
    evt_clr    = evt_hs ? onehot(evt_idx) : '0;
    pending_nx = ((pending & ~evt_clr) | (alarm_hit & alarm_en)) & ~disarm_clr;
    ptr_nx     = rr_ptr;
    if (evt_hs) ptr_nx = (int'(evt_idx) == NB_INTERFACES - 1) ? '0 : evt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_idx   <= '0;
    end else begin
      pending   <= pending_nx;
      rr_ptr    <= ptr_nx;
      evt_valid <= |pending_nx;
      if (!(evt_valid && !evt_ready && (pending_nx & onehot(evt_idx)) != '0))
        evt_idx <= first_from(pending_nx, ptr_nx);
    end
  end

endmodule

// File: tb/tb_timer_bank_ctrl.sv
// Directed bench for timer_bank_ctrl: a command/response vector table plus hand-written
// sequences for pulse timing, response back-pressure, event arbitration and mid-pulse reset.
module tb_timer_bank_ctrl;

  localparam int TW = 32;
  localparam int NB = 10;
  localparam int IW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready;
  logic [2:0]     cmd_op;
  logic [IW-1:0]  cmd_idx;
  logic [TW-1:0]  cmd_data;
  logic           rsp_valid, rsp_ready, rsp_err;
  logic [TW-1:0]  rsp_data;
  logic [NB-1:0]  start, capture, rst_capture, alarm_en, alarm_hit;
  logic [TW*NB-1:0] alarm, captured, counter;
  logic           evt_valid, evt_ready;
  logic [IW-1:0]  evt_idx;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [2:0]    op;
    logic [IW-1:0] idx;
    logic [TW-1:0] data;
    logic [TW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs [7];

  timer_bank_ctrl #(.TIMER_BITWIDTH(TW), .NB_INTERFACES(NB), .PULSE_CLKS(2), .SETTLE_CLKS(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .start(start), .capture(capture), .rst_capture(rst_capture),
    .alarm_en(alarm_en), .alarm(alarm), .captured(captured), .counter(counter),
    .alarm_hit(alarm_hit),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns one step (#1) after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [IW-1:0] idx, input logic [TW-1:0] data);
    bit ok = 1'b0;
    cmd_op = op; cmd_idx = idx; cmd_data = data; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      tests++; failed++;
      $display("[TB] FAIL accept_timeout: got cmd_ready=0, expected 1 within 40 cycles");
    end
  endtask

  task automatic waitRsp(input string name);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) begin
      tests++; failed++;
      $display("[TB] FAIL %s_rsp_timeout: got rsp_valid=0, expected 1 within 40 cycles", name);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_data = '0;
    rsp_ready = 1'b0; evt_ready = 1'b0; alarm_hit = '0;
    captured = '0; counter = '0;
    captured[0*TW +: TW] = 32'h0000_1234;
    captured[1*TW +: TW] = 32'hA5A5_0001;
    counter[9*TW +: TW]  = 32'h0000_0055;
    counter[3*TW +: TW]  = 32'h0000_0077;

    vecs[0] = '{op: 3'd0, idx: 4'd0,  data: 32'h0,     exp_data: 32'h0,         exp_err: 1'b0};
    vecs[1] = '{op: 3'd7, idx: 4'd9,  data: 32'h0,     exp_data: 32'h0000_0055, exp_err: 1'b0};
    vecs[2] = '{op: 3'd6, idx: 4'd1,  data: 32'h0,     exp_data: 32'hA5A5_0001, exp_err: 1'b0};
    vecs[3] = '{op: 3'd7, idx: 4'd12, data: 32'h0,     exp_data: 32'h0,         exp_err: 1'b1};
    vecs[4] = '{op: 3'd4, idx: 4'd2,  data: 32'h100,   exp_data: 32'h0,         exp_err: 1'b0};
    vecs[5] = '{op: 3'd4, idx: 4'd5,  data: 32'h500,   exp_data: 32'h0,         exp_err: 1'b0};
    vecs[6] = '{op: 3'd6, idx: 4'd15, data: 32'h0,     exp_data: 32'h0,         exp_err: 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_alarm_en", alarm_en, 0);
    checkOutput("rst_evt_valid", evt_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_release_cmd_ready", cmd_ready, 1);

    // START idx 3: two-cycle pulse, then response
    applyStimulus(3'd1, 4'd3, 32'h0);
    checkOutput("start_c1", start, 10'h008);
    checkOutput("start_c1_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    checkOutput("start_c2", start, 10'h008);
    @(posedge clk); #1;
    checkOutput("start_c3", start, 10'h000);
    checkOutput("start_rsp_valid", rsp_valid, 1);
    checkOutput("start_rsp_data", rsp_data, 0);
    checkOutput("start_rsp_err", rsp_err, 0);
    handshake();

    // CAPTURE idx 0: pulse, settle, sample, then held response
    applyStimulus(3'd2, 4'd0, 32'h0);
    checkOutput("capture_c1", capture, 10'h001);
    @(posedge clk); #1;
    checkOutput("capture_c2", capture, 10'h001);
    @(posedge clk); #1;
    checkOutput("capture_settle1", capture, 10'h000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("capture_sample_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    checkOutput("capture_rsp_valid", rsp_valid, 1);
    checkOutput("capture_rsp_data", rsp_data, 32'h1234);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("capture_hold%0d_valid", i), rsp_valid, 1);
      checkOutput($sformatf("capture_hold%0d_data", i), rsp_data, 32'h1234);
      checkOutput($sformatf("capture_hold%0d_cmd_ready", i), cmd_ready, 0);
    end
    handshake();

    // ARM idx 9
    applyStimulus(3'd4, 4'd9, 32'hDEAD_BEEF);
    checkOutput("arm9_alarm", alarm[319:288], 32'hDEAD_BEEF);
    checkOutput("arm9_en", alarm_en, 10'h200);
    waitRsp("arm9");
    handshake();

    // Vector table
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].op, vecs[v].idx, vecs[v].data);
      waitRsp($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d_rsp_data", v), rsp_data, vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_rsp_err", v), rsp_err, vecs[v].exp_err);
      handshake();
    end
    checkOutput("table_alarm_en", alarm_en, 10'h224);
    checkOutput("table_alarm2", alarm[2*TW +: TW], 32'h100);

    // START with out-of-range idx: error, no timer-side effect
    applyStimulus(3'd1, 4'd12, 32'h0);
    checkOutput("err_start_pulse", start | capture | rst_capture, 0);
    checkOutput("err_rsp_err", rsp_err, 1);
    checkOutput("err_rsp_data", rsp_data, 0);
    checkOutput("err_alarm_en", alarm_en, 10'h224);
    handshake();

    // Event arbitration: simultaneous hits on 2,5,9, then a re-hit on 2 during the 5 grant
    evt_ready = 1'b1;
    alarm_hit = 10'h224;
    @(posedge clk); #1;
    alarm_hit = '0;
    checkOutput("evt_first_valid", evt_valid, 1);
    checkOutput("evt_first_idx", evt_idx, 2);
    @(posedge clk); #1;
    checkOutput("evt_second_idx", evt_idx, 5);
    alarm_hit = 10'h004;
    @(posedge clk); #1;
    alarm_hit = '0;
    checkOutput("evt_third_idx", evt_idx, 9);
    @(posedge clk); #1;
    checkOutput("evt_fourth_valid", evt_valid, 1);
    checkOutput("evt_fourth_idx", evt_idx, 2);
    @(posedge clk); #1;
    checkOutput("evt_drained", evt_valid, 0);

    // Leave an event pending, then reset during an RST_CAPTURE pulse
    evt_ready = 1'b0;
    alarm_hit = 10'h200;
    @(posedge clk); #1;
    alarm_hit = '0;
    checkOutput("pend_valid", evt_valid, 1);
    checkOutput("pend_idx", evt_idx, 9);
    applyStimulus(3'd3, 4'd4, 32'h0);
    checkOutput("rstcap_c1", rst_capture, 10'h010);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_rst_capture", rst_capture, 0);
    checkOutput("midrst_evt_valid", evt_valid, 0);
    checkOutput("midrst_cmd_ready", cmd_ready, 0);
    checkOutput("midrst_alarm_en", alarm_en, 0);
    checkOutput("midrst_alarm9", alarm[319:288], 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("postrst_cmd_ready", cmd_ready, 1);
    checkOutput("postrst_evt_valid", evt_valid, 0);
    checkOutput("postrst_rsp_valid", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/timer_bank_ctrl.md
Name: timer_bank_ctrl

Overview:
- Command-driven sequencer for the multi-channel timer bank. A single host issues commands through a valid/ready channel; the block generates the per-channel start, capture and rst_capture pulses and programs the alarm registers.
- It reads back captured and counter values and returns exactly one response per command.
- A round-robin arbiter reports per-channel alarm hits to the host as an event stream.

Parameters:
- TIMER_BITWIDTH, 32, width of one timer channel.
- NB_INTERFACES, 10, number of timer channels.
- PULSE_CLKS, 2, width in clk cycles of generated start/capture/rst_capture pulses (>=1).
- SETTLE_CLKS, 2, wait in cycles after a capture pulse before sampling captured.
- IDX_W (localparam), $clog2(NB_INTERFACES), channel index width.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  3  command opcode: 0 NOP, 1 START, 2 CAPTURE, 3 RST_CAPTURE, 4 ARM, 5 DISARM, 6 RD_CAPTURED, 7 RD_COUNTER.
- cmd_idx  in  IDX_W  target channel.
- cmd_data  in  TIMER_BITWIDTH  alarm value for ARM.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_data  out  TIMER_BITWIDTH  read data; 0 for non-read commands.
- rsp_err  out  1  error flag: cmd_idx >= NB_INTERFACES.
- start, capture, rst_capture  out  NB_INTERFACES  per-channel pulses to the timer bank.
- alarm_en  out  NB_INTERFACES  per-channel alarm enables.
- alarm  out  TIMER_BITWIDTH*NB_INTERFACES  alarm values; channel i occupies [i*TIMER_BITWIDTH +: TIMER_BITWIDTH].
- captured, counter  in  TIMER_BITWIDTH*NB_INTERFACES  per-channel values from the timer bank, same slicing.
- alarm_hit  in  NB_INTERFACES  one-cycle alarm pulses, already in the clk domain.
- evt_valid  out  1  alarm event pending.
- evt_ready  in  1  event accepted.
- evt_idx  out  IDX_W  channel index of the reported event.

Behaviour:
- Reset (rst high at a clk edge):
  - State returns to IDLE.
  - All outputs go to 0: cmd_ready, rsp_*, start, capture, rst_capture, alarm_en, alarm, evt_*.
  - All pending bits clear; round-robin pointer resets to 0.
  - A pulse in progress drops at that edge.
  - cmd_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, PULSE, SETTLE, SAMPLE, RESP.
  - cmd_ready=1 only in IDLE.
  - On accept, the block registers op, idx and data.
- Accepting a command with idx >= NB_INTERFACES:
  - Goes directly to RESP with rsp_err=1 and rsp_data=0.
  - Has no timer-side effect.
- NOP, ARM, DISARM:
  - Go to RESP on the next cycle.
  - ARM: alarm slice <= data and alarm_en[idx] <= 1, both visible the cycle after accept.
  - DISARM: alarm_en[idx] <= 0 and pending[idx] cleared.
- START, RST_CAPTURE:
  - The selected pulse bit is high for exactly PULSE_CLKS cycles, starting the cycle after accept (PULSE state).
  - RESP follows immediately after the pulse.
- CAPTURE:
  - capture[idx] is pulsed for PULSE_CLKS cycles, then SETTLE holds for SETTLE_CLKS cycles.
  - SAMPLE then registers the captured slice of idx into rsp_data, then RESP.
- RD_CAPTURED, RD_COUNTER:
  - SAMPLE in the cycle after accept registers the slice; RESP follows.
  - rsp_valid is first seen 2 cycles after accept.
- RESP:
  - rsp_valid=1 with rsp_data, rsp_err stable until rsp_ready.
  - On the handshake, return to IDLE; the next command can be accepted the following cycle.
  - Exactly one response is produced per accepted command, in order.
- Only one pulse bit is ever high at a time. Outputs not being pulsed hold 0.
- Event arbiter (runs independently of the FSM):
  - pending[i] is set when alarm_hit[i] & alarm_en[i]; repeated hits on a pending channel coalesce.
  - evt_valid = |pending.
  - evt_idx is the first pending index at or after the pointer, searching with wrap-around.
  - evt_idx is registered and held stable while evt_valid & !evt_ready.
  - On handshake: pending[evt_idx] clears and the pointer moves to evt_idx+1, wrapping NB_INTERFACES-1 -> 0.
  - A set and a clear of the same bit in the same cycle: set wins.
  - DISARM clear and a hit in the same cycle: clear wins, since alarm_en is already 0 from the next cycle.

Test Plan:
- Reset, then START idx 3 with PULSE_CLKS=2 -> start=0x008 for exactly 2 cycles beginning one cycle after accept; rsp_valid the following cycle with rsp_data=0 and rsp_err=0.
- CAPTURE idx 0 with captured slice 0 = 0x1234 -> capture[0] high for 2 cycles, 2 settle cycles, then rsp_data=0x1234 and rsp_valid; hold rsp_ready=0 for 5 cycles -> rsp stable and cmd_ready=0 throughout.
- ARM idx 9 with data 0xDEADBEEF -> alarm[319:288]=0xDEADBEEF and alarm_en[9]=1; RD_COUNTER idx 9 with counter slice 9 = 0x55 -> rsp_data=0x55.
- Command with idx 12 -> rsp_err=1, rsp_data=0, no change on any timer-side output.
- Channels 2, 5, 9 armed, simultaneous alarm_hit, evt_ready=1 -> events reported in order 2, 5, 9; a new hit on 2 during the 5 grant -> next events 9 then 2.
- Assert rst while rst_capture[4] is mid-pulse -> rst_capture=0 at that edge; all pending bits clear; cmd_ready=1 the cycle after rst deasserts.
